i2c_slave_ctrl: RTL and testbench
=================================

// Module: i2c_slave_ctrl
// PURPOSE
//  Sequencing FSM for the I2C slave (transmit-only: master-read responder). Consumes start/stop/address
//  decode results and SCL edge pulses, and drives rx/tx shift-register enables, FIFO pop and SDA output
//  mode. Holds the bit/ACK timer. Sits between the bus decode/edge logic and the shift register/TX FIFO.
// PARAMETERS
//  TIMEOUT_CYCLES  4096  clk cycles SCL may stay low outside IDLE before abort (I2C_TIMEOUT_EN only)
//  TO_W            13    width of timeout counter; must satisfy 2**TO_W > TIMEOUT_CYCLES
// PORTS
//  clk             in   1  system clock, all flops rising-edge
//  n_rst           in   1  asynchronous active-low reset
//  start_found     in   1  1-cycle pulse: START/repeated START detected
//  stop_found      in   1  1-cycle pulse: STOP detected
//  rising_edge     in   1  1-cycle pulse: SCL rose (synchronised)
//  falling_edge    in   1  1-cycle pulse: SCL fell (synchronised)
//  address_match   in   1  received address byte equals slave address
//  rw_mode         in   1  R/W bit of received address byte (1 = master read)
//  sda_in          in   1  synchronised SDA, sampled for master ACK
//  scl             in   1  synchronised SCL level (timeout only)
//  rx_enable       out  1  shift register captures SDA on rising_edge
//  tx_enable       out  1  shift register shifts out on falling_edge
//  read_enable     out  1  1-cycle TX FIFO pop
//  load_data       out  1  1-cycle parallel load of shift register from FIFO head
//  sda_mode        out  2  00 release(1), 01 drive 0 (ACK), 10 drive 1 (NACK), 11 shift-register bit
//  bus_timeout     out  1  1-cycle pulse on timeout abort (tied 0 without I2C_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: FSM=IDLE, counters 0, all outputs 0 (sda_mode=00). All outputs registered-state decoded (Moore).
//  Timer (bit_cnt 0..9, cleared in IDLE and on start_found): counts rising_edge; emits 1-cycle pulses
//   byte_received on 8th rising, ack_prep on next falling, check_ack on 9th rising, ack_done on 9th falling
//   (then bit_cnt->0 for next byte). Edge inputs ignored while in IDLE.
//  States / transitions (priority: stop_found > start_found > others):
//   IDLE      : start_found -> RX_ADDR.
//   RX_ADDR   : rx_enable=1; byte_received -> ADDR_CHK.
//   ADDR_CHK  : 1 cycle; address_match&rw_mode -> ACK_WAIT, else -> NACK_WAIT.
//   ACK_WAIT  : ack_prep -> ADDR_ACK.   ADDR_ACK  : sda_mode=01; ack_done -> LOAD.
//   NACK_WAIT : ack_prep -> ADDR_NACK.  ADDR_NACK : sda_mode=10; ack_done -> IDLE.
//   LOAD      : load_data=1, read_enable=1 for exactly 1 cycle -> TX_BYTE.
//   TX_BYTE   : sda_mode=11, tx_enable=1; ack_prep -> MACK_WAIT.
//   MACK_WAIT : sda_mode=00; check_ack: sda_in=0 -> MACK_OK, sda_in=1 -> MNACK.
//   MACK_OK   : ack_done -> LOAD.   MNACK : ack_done -> IDLE.
//  stop_found in any state -> IDLE next cycle; sda_mode 00 that cycle on; no pop.
//  start_found in any non-IDLE state (repeated START) -> RX_ADDR, timer cleared.
//  stop_found and start_found same cycle: stop wins.
//  Edge pulse coincident with state entry is acted on in that state only from the next cycle.
//  Async reset mid-transfer: immediate return to reset values; SDA released.
// CONFIGURATION
//  I2C_TIMEOUT_EN defined: counter counts clk while scl=0 and FSM!=IDLE, clears when scl=1; on reaching
//   TIMEOUT_CYCLES -> IDLE, bus_timeout pulses 1 cycle, counter cleared. Undefined: no counter, bus_timeout=0.
// STRUCTURE
//  Package i2c_slave_pkg: state enum, sda_mode constants (SDA_IDLE/SDA_ACK/SDA_NACK/SDA_TX), BYTE_BITS=8.
//  Sub-module i2c_bit_timer: bit_cnt and the four timing pulses (in: clk,n_rst,enable,clear,edges).
// TESTING
//  1 Reset mid-TX_BYTE (n_rst low 1 cycle) -> all outputs 0, sda_mode=00, next start_found needed.
//  2 START, addr 0x71 (match, rw=1), 8 rising -> ADDR_CHK 1 cycle; sda_mode=01 from ack_prep to ack_done;
//    then load_data/read_enable single-cycle pulse, sda_mode=11.
//  3 START, addr 0x70 (rw=0) -> sda_mode=10 during ACK slot, IDLE after ack_done, no read_enable ever.
//  4 Two read bytes: master ACK (sda_in=0 at check_ack) -> second LOAD/pop; master NACK -> IDLE, exactly 2 pops.
//  5 stop_found mid-TX_BYTE (bit 4) -> IDLE next cycle, sda_mode=00; repeated START mid-byte -> RX_ADDR, bit_cnt=0.
//  6 With I2C_TIMEOUT_EN, TIMEOUT_CYCLES=16: hold scl=0 in RX_ADDR 16 cycles -> bus_timeout pulse, IDLE;
//    15 cycles then scl=1 -> no timeout.

Source files
------------

// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the transmit-only I2C slave sequencer.
package i2c_slave_pkg;

  localparam int BYTE_BITS = 8;
  localparam int BIT_CNT_W = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RX_ADDR,
    ST_ADDR_CHK,
    ST_ACK_WAIT,
    ST_ADDR_ACK,
    ST_NACK_WAIT,
    ST_ADDR_NACK,
    ST_LOAD,
    ST_TX_BYTE,
    ST_MACK_WAIT,
    ST_MACK_OK,
    ST_MNACK
  } state_t;

  localparam logic [1:0] SDA_IDLE = 2'b00;
  localparam logic [1:0] SDA_ACK  = 2'b01;
  localparam logic [1:0] SDA_NACK = 2'b10;
  localparam logic [1:0] SDA_TX   = 2'b11;

endpackage

// File: rtl/i2c_bit_timer.sv
// Bit/ACK timer: counts SCL rising edges within a byte frame (8 data bits + ACK)
// and emits single-cycle phase pulses derived from the edge that caused them.
module i2c_bit_timer
  import i2c_slave_pkg::*;
(
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 rising_edge,
  input  logic                 falling_edge,
  output logic                 byte_received,
  output logic                 ack_prep,
  output logic                 check_ack,
  output logic                 ack_done,
  output logic [BIT_CNT_W-1:0] bit_cnt
);

  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(BYTE_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] ACK_BIT   = BIT_CNT_W'(BYTE_BITS);
  localparam logic [BIT_CNT_W-1:0] FRAME_END = BIT_CNT_W'(BYTE_BITS + 1);

  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 rise, fall;

  assign rise = enable & ~clear & rising_edge;
  assign fall = enable & ~clear & falling_edge;

  // bit_cnt holds the number of rising edges seen in the current frame
  assign byte_received = rise && (bit_cnt_q == LAST_DATA);
  assign check_ack     = rise && (bit_cnt_q == ACK_BIT);
  assign ack_prep      = fall && (bit_cnt_q == ACK_BIT);
  assign ack_done      = fall && (bit_cnt_q == FRAME_END);
  assign bit_cnt       = bit_cnt_q;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (clear || ack_done) begin
      bit_cnt_d = '0;
    end else if (rise && (bit_cnt_q < FRAME_END)) begin
      bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_cnt_q <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/i2c_slave_ctrl.sv
// Sequencing FSM for a transmit-only I2C slave (master-read responder).
// Optional SCL-low bus timeout is built when I2C_TIMEOUT_EN is defined.
module i2c_slave_ctrl
  import i2c_slave_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 13
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start_found,
  input  logic                 stop_found,
  input  logic                 rising_edge,
  input  logic                 falling_edge,
  input  logic                 address_match,
  input  logic                 rw_mode,
  input  logic                 sda_in,
  input  logic                 scl,
  output logic                 rx_enable,
  output logic                 tx_enable,
  output logic                 read_enable,
  output logic                 load_data,
  output logic [1:0]           sda_mode,
  output logic                 bus_timeout,
  output state_t               dbg_state,
  output logic [BIT_CNT_W-1:0] dbg_bit_cnt
);

  state_t state_q, state_d;
  logic   byte_received, ack_prep, check_ack, ack_done;
  logic   timeout_hit;

  i2c_bit_timer u_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable       (state_q != ST_IDLE),
    .clear        ((state_q == ST_IDLE) || start_found),
    .rising_edge  (rising_edge),
    .falling_edge (falling_edge),
    .byte_received(byte_received),
    .ack_prep     (ack_prep),
    .check_ack    (check_ack),
    .ack_done     (ack_done),
    .bit_cnt      (dbg_bit_cnt)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // STOP beats a coincident START; a START anywhere restarts address reception
  always_comb begin
    state_d = state_q;
    if (stop_found) begin
      state_d = ST_IDLE;
    end else if (start_found) begin
      state_d = ST_RX_ADDR;
    end else if (timeout_hit) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_RX_ADDR:   if (byte_received) state_d = ST_ADDR_CHK;
        ST_ADDR_CHK:  state_d = (address_match && rw_mode) ? ST_ACK_WAIT : ST_NACK_WAIT;
        ST_ACK_WAIT:  if (ack_prep) state_d = ST_ADDR_ACK;
        ST_ADDR_ACK:  if (ack_done) state_d = ST_LOAD;
        ST_NACK_WAIT: if (ack_prep) state_d = ST_ADDR_NACK;
        ST_ADDR_NACK: if (ack_done) state_d = ST_IDLE;
        ST_LOAD:      state_d = ST_TX_BYTE;
        ST_TX_BYTE:   if (ack_prep) state_d = ST_MACK_WAIT;
        ST_MACK_WAIT: if (check_ack) state_d = sda_in ? ST_MNACK : ST_MACK_OK;
        ST_MACK_OK:   if (ack_done) state_d = ST_LOAD;
        ST_MNACK:     if (ack_done) state_d = ST_IDLE;
        default:      state_d = state_q;
      endcase
    end
  end

  always_comb begin
    rx_enable   = 1'b0;
    tx_enable   = 1'b0;
    read_enable = 1'b0;
    load_data   = 1'b0;
    sda_mode    = SDA_IDLE;
    case (state_q)
      ST_RX_ADDR:   rx_enable = 1'b1;
      ST_ADDR_ACK:  sda_mode = SDA_ACK;
      ST_ADDR_NACK: sda_mode = SDA_NACK;
      ST_LOAD: begin
        load_data   = 1'b1;
        read_enable = 1'b1;
      end
      ST_TX_BYTE: begin
        sda_mode  = SDA_TX;
        tx_enable = 1'b1;
      end
      default: ;
    endcase
  end

  assign dbg_state = state_q;

`ifdef I2C_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_pulse_q;

  // Counts consecutive SCL-low cycles while a transfer is in progress
  assign timeout_hit = (state_q != ST_IDLE) && !scl &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_cnt_d = to_cnt_q + TO_W'(1);
    if ((state_q == ST_IDLE) || scl || timeout_hit) begin
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      to_cnt_q   <= '0;
      to_pulse_q <= 1'b0;
    end else begin
      to_cnt_q   <= to_cnt_d;
      to_pulse_q <= timeout_hit && !stop_found && !start_found;
    end
  end

  assign bus_timeout = to_pulse_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = scl ^ (TIMEOUT_CYCLES != 0) ^ (TO_W != 0);
  assign timeout_hit        = 1'b0;
  assign bus_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Bench for i2c_slave_ctrl: directed table, corner sequences and randomized
// read transfers checked against a transaction-level expectation.
`timescale 1ns/1ps
module tb_i2c_slave_ctrl;
  import i2c_slave_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start_found = 1'b0, stop_found = 1'b0;
  logic       rising_edge = 1'b0, falling_edge = 1'b0;
  logic       address_match = 1'b0, rw_mode = 1'b0, sda_in = 1'b1, scl = 1'b1;
  logic       rx_enable, tx_enable, read_enable, load_data, bus_timeout;
  logic [1:0] sda_mode;
  state_t     dbg_state;
  logic [BIT_CNT_W-1:0] dbg_bit_cnt;
  logic [6:0] o_vec;

  int total = 0;
  int bad = 0;
  int pops_seen = 0;
  int pops_exp = 0;
  logic [7:0] exp_q[$];

  // {bus_timeout, rx_enable, tx_enable, read_enable, load_data, sda_mode}
  localparam logic [6:0] V_IDLE = 7'b0000000;
  localparam logic [6:0] V_RX   = 7'b0100000;
  localparam logic [6:0] V_ACK  = 7'b0000001;
  localparam logic [6:0] V_NACK = 7'b0000010;
  localparam logic [6:0] V_LOAD = 7'b0001100;
  localparam logic [6:0] V_TX   = 7'b0010011;
  localparam logic [6:0] V_TO   = 7'b1000000;

  i2c_slave_ctrl #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .clk(clk), .n_rst(n_rst), .start_found(start_found), .stop_found(stop_found),
    .rising_edge(rising_edge), .falling_edge(falling_edge),
    .address_match(address_match), .rw_mode(rw_mode), .sda_in(sda_in), .scl(scl),
    .rx_enable(rx_enable), .tx_enable(tx_enable), .read_enable(read_enable),
    .load_data(load_data), .sda_mode(sda_mode), .bus_timeout(bus_timeout),
    .dbg_state(dbg_state), .dbg_bit_cnt(dbg_bit_cnt)
  );

  assign o_vec = {bus_timeout, rx_enable, tx_enable, read_enable, load_data, sda_mode};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: sim time exceeded, got running want finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // ---------------- checks ----------------
  task automatic check_vec(input string nm, input logic [6:0] exp);
    total++;
    if (o_vec !== exp) begin
      bad++;
      $display("FAIL %s: outputs got %b want %b", nm, o_vec, exp);
    end
  endtask

  task automatic check_val(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Scoreboard: every observed FIFO pop must have been predicted beforehand
  always @(negedge clk) begin
    if (n_rst && read_enable) begin
      pops_seen++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pop: read_enable got 1 want 0");
      end else begin
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic expect_pop(input logic [7:0] id);
    exp_q.push_back(id);
    pops_exp++;
  endtask

  // ---------------- drivers ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start();
    start_found = 1'b1; tick(); start_found = 1'b0;
  endtask

  task automatic do_stop();
    stop_found = 1'b1; tick(); stop_found = 1'b0;
  endtask

  task automatic do_rise();
    rising_edge = 1'b1; tick(); rising_edge = 1'b0;
  endtask

  task automatic do_fall();
    falling_edge = 1'b1; tick(); falling_edge = 1'b0;
  endtask

  task automatic do_pairs(input int n);
    repeat (n) begin
      do_rise(); tick(); do_fall(); tick();
    end
  endtask

  task automatic gap();
    sda_in = 1'($urandom_range(0, 1));
    tick($urandom_range(1, 3));
  endtask

  // Matching read address, ACKed, first byte loaded: ends in the transmit phase
  task automatic go_tx(input string nm);
    address_match = 1'b1; rw_mode = 1'b1;
    do_start(); do_pairs(7); do_rise(); tick(); do_fall(); do_rise(); do_fall();
    expect_pop(8'hA0);
    tick();
    check_vec(nm, V_TX);
  endtask

  // ---------------- directed table ----------------
  typedef enum int {A_RESET, A_IDLE, A_START, A_STOP, A_RISE, A_FALL, A_PAIRS} act_e;
  typedef struct {
    string      nm;
    act_e       act;
    int         n;
    logic       match;
    logic       rw;
    logic       pop;
    logic [6:0] exp;
  } row_t;
  row_t tbl[$];

  task automatic add(input string nm, input act_e a, input int n, input logic m,
                     input logic rw, input logic pop, input logic [6:0] e);
    row_t r;
    r.nm = nm; r.act = a; r.n = n; r.match = m; r.rw = rw; r.pop = pop; r.exp = e;
    tbl.push_back(r);
  endtask

  task automatic build_table();
    add("reset",          A_RESET, 2, 0, 0, 0, V_IDLE);
    add("idle_edges",     A_PAIRS, 3, 0, 0, 0, V_IDLE);
    add("a71_start",      A_START, 1, 1, 1, 0, V_RX);
    add("a71_bits7",      A_PAIRS, 7, 0, 0, 0, V_RX);
    add("a71_addr_chk",   A_RISE,  1, 0, 0, 0, V_IDLE);
    add("a71_ack_wait",   A_IDLE,  1, 0, 0, 0, V_IDLE);
    add("a71_ack_prep",   A_FALL,  1, 0, 0, 0, V_ACK);
    add("a71_ack_rise",   A_RISE,  1, 0, 0, 0, V_ACK);
    add("a71_ack_hold",   A_IDLE,  2, 0, 0, 0, V_ACK);
    add("a71_load",       A_FALL,  1, 0, 0, 1, V_LOAD);
    add("a71_tx",         A_IDLE,  1, 0, 0, 0, V_TX);
    add("a71_tx_hold",    A_IDLE,  3, 0, 0, 0, V_TX);
    add("a71_stop",       A_STOP,  1, 0, 0, 0, V_IDLE);
    add("a70_start",      A_START, 1, 1, 0, 0, V_RX);
    add("a70_bits7",      A_PAIRS, 7, 0, 0, 0, V_RX);
    add("a70_addr_chk",   A_RISE,  1, 0, 0, 0, V_IDLE);
    add("a70_nack_wait",  A_IDLE,  1, 0, 0, 0, V_IDLE);
    add("a70_nack_prep",  A_FALL,  1, 0, 0, 0, V_NACK);
    add("a70_nack_rise",  A_RISE,  1, 0, 0, 0, V_NACK);
    add("a70_nack_done",  A_FALL,  1, 0, 0, 0, V_IDLE);
    add("a70_idle_after", A_IDLE,  3, 0, 0, 0, V_IDLE);
    add("nm_start",       A_START, 1, 0, 1, 0, V_RX);
    add("nm_bits7",       A_PAIRS, 7, 0, 0, 0, V_RX);
    add("nm_addr_chk",    A_RISE,  1, 0, 0, 0, V_IDLE);
    add("nm_wait",        A_IDLE,  1, 0, 0, 0, V_IDLE);
    add("nm_nack_prep",   A_FALL,  1, 0, 0, 0, V_NACK);
    add("nm_nack_rise",   A_RISE,  1, 0, 0, 0, V_NACK);
    add("nm_nack_done",   A_FALL,  1, 0, 0, 0, V_IDLE);
  endtask

  task automatic apply_row(input row_t r);
    case (r.act)
      A_RESET: begin n_rst = 1'b0; tick(r.n); n_rst = 1'b1; tick(); end
      A_IDLE:  tick(r.n);
      A_START: begin address_match = r.match; rw_mode = r.rw; do_start(); end
      A_STOP:  do_stop();
      A_RISE:  do_rise();
      A_FALL:  do_fall();
      A_PAIRS: do_pairs(r.n);
      default: tick();
    endcase
    if (r.pop) expect_pop(8'h01);
    check_vec(r.nm, r.exp);
  endtask

  // ---------------- corner sequences ----------------
  task automatic seq_reset_mid_tx();
    go_tx("rst_go_tx");
    do_pairs(2);
    n_rst = 1'b0;
    #2;
    check_vec("rst_async_outputs", V_IDLE);
    check_val("rst_async_state", int'(dbg_state), int'(ST_IDLE));
    tick();
    n_rst = 1'b1;
    tick();
    check_vec("rst_released", V_IDLE);
    do_pairs(2);
    check_vec("rst_needs_start", V_IDLE);
    do_start();
    check_vec("rst_restart", V_RX);
    do_stop();
  endtask

  task automatic seq_two_bytes();
    int base;
    base = pops_seen;
    go_tx("two_go_tx");
    do_pairs(7); do_rise();
    check_vec("two_b1_bit8", V_TX);
    tick(); do_fall();
    check_vec("two_b1_mack_wait", V_IDLE);
    check_val("two_b1_state", int'(dbg_state), int'(ST_MACK_WAIT));
    sda_in = 1'b0; tick(); do_rise(); sda_in = 1'b1; tick(); do_fall();
    expect_pop(8'hB1);
    check_vec("two_b2_load", V_LOAD);
    tick();
    check_vec("two_b2_tx", V_TX);
    do_pairs(7); do_rise(); tick(); do_fall();
    check_vec("two_b2_mack_wait", V_IDLE);
    sda_in = 1'b1; tick(); do_rise(); tick(); do_fall();
    check_vec("two_mnack_idle", V_IDLE);
    tick(3);
    check_val("two_pop_count", pops_seen - base, 2);
  endtask

  task automatic seq_stop_mid_tx();
    go_tx("stop_go_tx");
    do_pairs(4);
    do_stop();
    check_vec("stop_mid_tx", V_IDLE);
    check_val("stop_mid_tx_state", int'(dbg_state), int'(ST_IDLE));
    do_pairs(2);
    check_vec("stop_edges_ignored", V_IDLE);
  endtask

  task automatic seq_restart();
    go_tx("rs_go_tx");
    do_pairs(3); do_rise();
    do_start();
    check_vec("rs_rx_addr", V_RX);
    check_val("rs_bit_cnt", int'(dbg_bit_cnt), 0);
    do_pairs(7);
    check_vec("rs_bits7", V_RX);
    do_rise();
    check_val("rs_addr_chk", int'(dbg_state), int'(ST_ADDR_CHK));
    tick();
    check_val("rs_ack_wait", int'(dbg_state), int'(ST_ACK_WAIT));
    do_stop();
  endtask

  task automatic seq_stop_start();
    go_tx("ss_go_tx");
    start_found = 1'b1; stop_found = 1'b1; tick();
    start_found = 1'b0; stop_found = 1'b0;
    check_vec("ss_stop_wins", V_IDLE);
  endtask

`ifdef I2C_TIMEOUT_EN
  task automatic seq_timeout();
    address_match = 1'b0; rw_mode = 1'b0;
    do_start();
    scl = 1'b0; tick(15);
    check_vec("to_15_low", V_RX);
    scl = 1'b1; tick();
    check_vec("to_scl_high", V_RX);
    scl = 1'b0; tick(15);
    check_vec("to_15_again", V_RX);
    tick();
    check_vec("to_16_fire", V_TO);
    tick();
    check_vec("to_pulse_end", V_IDLE);
    scl = 1'b1;
  endtask
`endif

  // ---------------- randomized transfers ----------------
  // Expectations follow the bus protocol: the slave ACKs only a matching read
  // address, then serves bytes until the master NACKs one.
  task automatic rand_xfer(input int id);
    logic ok;
    int   nb;
    address_match = 1'($urandom_range(0, 1));
    rw_mode       = 1'($urandom_range(0, 1));
    ok = address_match & rw_mode;
    nb = $urandom_range(1, 3);
    do_start();
    check_vec("rnd_start", V_RX);
    for (int b = 0; b < 7; b++) begin
      gap(); do_rise(); gap(); do_fall();
    end
    check_vec("rnd_addr_bits", V_RX);
    gap(); do_rise();
    check_vec("rnd_addr_chk", V_IDLE);
    gap(); do_fall();
    check_vec("rnd_ack_slot", ok ? V_ACK : V_NACK);
    gap(); do_rise(); gap(); do_fall();
    if (!ok) begin
      check_vec("rnd_nack_end", V_IDLE);
      gap();
      return;
    end
    expect_pop(8'(id));
    check_vec("rnd_load", V_LOAD);
    for (int k = 0; k < nb; k++) begin
      tick();
      check_vec("rnd_tx", V_TX);
      for (int b = 0; b < 8; b++) begin
        gap(); do_rise(); gap(); do_fall();
        if (b < 7) check_vec("rnd_tx_bit", V_TX);
      end
      check_vec("rnd_mack_wait", V_IDLE);
      gap();
      sda_in = (k == nb - 1);
      do_rise(); gap(); do_fall();
      if (k == nb - 1) begin
        check_vec("rnd_mnack_idle", V_IDLE);
      end else begin
        expect_pop(8'(id));
        check_vec("rnd_next_load", V_LOAD);
      end
    end
    gap();
  endtask

  // ---------------- main ----------------
  initial begin
    build_table();
    for (int i = 0; i < tbl.size(); i++) apply_row(tbl[i]);
    seq_reset_mid_tx();
    seq_two_bytes();
    seq_stop_mid_tx();
    seq_restart();
    seq_stop_start();
`ifdef I2C_TIMEOUT_EN
    seq_timeout();
`endif
    for (int t = 0; t < 20; t++) rand_xfer(t);
    tick(3);
    check_val("sb_empty", exp_q.size(), 0);
    check_val("pop_count", pops_seen, pops_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
